mul_hilo_stage: RTL and testbench
=================================

// Module: mul_hilo_stage
// PURPOSE
//  Sequencing and writeback stage downstream of the combinational arithmetic_mult array.
//  Registers the operands m and q, and holds them stable while the multiplier output settles.
//  Captures the 64-bit product into the HI/LO special registers with a start/busy/done handshake.
//  HI/LO are also directly writable from the bus (mthi/mtlo) and feed the datapath read mux.
// PARAMETERS
//  SETTLE_CYCLES  2   cycles the operands are held before prod_in is captured; legal range 1..15
//  CNT_W          4   settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  clk      in   1   system clock, rising edge
//  clr      in   1   asynchronous active-high reset
//  start    in   1   multiply request; sampled only in IDLE
//  m_in     in   32  multiplicand from datapath
//  q_in     in   32  multiplier from datapath
//  m_out    out  32  registered multiplicand -> arithmetic_mult.m
//  q_out    out  32  registered multiplier -> arithmetic_mult.q
//  prod_in  in   64  arithmetic_mult.out (two's-complement product of m_out*q_out)
//  bus_in   in   32  datapath bus, for mthi/mtlo
//  hi_wr    in   1   write bus_in into HI
//  lo_wr    in   1   write bus_in into LO
//  busy     out  1   high in SETTLE
//  done     out  1   one-cycle pulse: HI/LO updated by a multiply
//  hi_out   out  32  HI register (prod[63:32])
//  lo_out   out  32  LO register (prod[31:0])
// BEHAVIOUR
//  - clr (async, any state): state=IDLE, cnt=0; m_out, q_out, hi_out, lo_out, busy, done all 0.
//    An in-flight multiply is discarded and HI/LO are not written.
//  - States: IDLE, SETTLE (2-bit encoding; unused codes recover to IDLE).
//  - IDLE & start: on the edge, m_out<=m_in, q_out<=q_in, cnt<=SETTLE_CYCLES-1, go to SETTLE.
//  - SETTLE, cnt!=0: cnt<=cnt-1. Operands are held; start is ignored.
//  - SETTLE, cnt==0: on the edge, {hi_out,lo_out}<=prod_in, done<=1, go to IDLE.
//  - Latency: done=1 and HI/LO are valid SETTLE_CYCLES+1 edges after the start edge.
//    Throughput is one multiply per SETTLE_CYCLES+1 cycles.
//  - done is registered and high for exactly one cycle. start in the done cycle is accepted (back-to-back).
//  - busy = (state==SETTLE), decoded from the state register (glitch-free).
//  - hi_wr/lo_wr: honoured in any state and act on the edge.
//    On the capture edge the product wins and the same-cycle bus write is dropped.
//    A bus write during SETTLE is later overwritten by the product.
//  - Arithmetic: no sign/width manipulation here. prod_in is split verbatim; signedness is owned by the array.
//  - m_out/q_out hold their last values in IDLE (no toggling, saves power on the array).
// CONFIGURATION
//  MUL_ZERO_SKIP_EN defined:
//   - IDLE & start & (m_in==0 | q_in==0): on the same edge HI<=0, LO<=0, done<=1, state stays IDLE.
//     busy never rises; m_out/q_out still load m_in/q_in.
//   - This path also overrides a same-cycle hi_wr/lo_wr.
//  MUL_ZERO_SKIP_EN undefined: zero operands take the normal SETTLE path. Results are identical; latency is full.
// STRUCTURE
//  - Package cpu_mdu_pkg: mdu_state_t enum {IDLE, SETTLE}; localparam HI_LSB=32.
//    Also a function clog2 for CNT_W checks, shared with the future divider stage.
//  - One sub-module: mdu_settle_counter (load/decrement/zero-flag, CNT_W wide). Everything else stays in this file.
//  - Elaboration check: error if SETTLE_CYCLES<1 or SETTLE_CYCLES>=2**CNT_W.
// TESTING (bench instantiates arithmetic_mult between m_out/q_out and prod_in; SETTLE_CYCLES=2)
//  1 start, m=7, q=-3 -> busy for 2 cycles; done at edge 3; HI=FFFFFFFF, LO=FFFFFFEB.
//  2 m=q=7FFFFFFF -> HI=3FFFFFFF, LO=00000001. Then start in the done cycle with m=80000000, q=2
//    -> accepted; HI=FFFFFFFF, LO=00000000.
//  3 start during busy with m=5, q=5 -> ignored; first result unchanged; only one done pulse.
//  4 hi_wr=1 bus_in=DEADBEEF in IDLE -> HI=DEADBEEF, LO unchanged.
//    lo_wr on the capture edge -> LO=product, bus value lost.
//  5 clr asserted mid-SETTLE (async, between edges) -> all outputs 0 immediately; no done; HI/LO stay 0.
//  6 m=0, q=1234: with MUL_ZERO_SKIP_EN -> done at edge 1, busy never 1, HI=LO=0.
//    Without MUL_ZERO_SKIP_EN -> done at edge 3, HI=LO=0.

Source files
------------

// File: rtl/cpu_mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit stages.
package cpu_mdu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1
  } mdu_state_t;

  localparam int HI_LSB = 32;

  // Bits needed to hold values 0..value-1; used by elaboration-time width checks.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_settle_counter.sv
// Down-counter timing how long the multiplier operands are held before capture.
module mdu_settle_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             cnt_zero
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/mul_hilo_stage.sv
// Multiply sequencing and HI/LO writeback stage behind the combinational multiplier array.
// Optional build macro MUL_ZERO_SKIP_EN: zero operands complete in the start cycle.
module mul_hilo_stage
  import cpu_mdu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] m_in,
  input  logic [31:0] q_in,
  output logic [31:0] m_out,
  output logic [31:0] q_out,
  input  logic [63:0] prod_in,
  input  logic [31:0] bus_in,
  input  logic        hi_wr,
  input  logic        lo_wr,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CNT_NEED = clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES >= (1 << CNT_W)) || (CNT_W < CNT_NEED)) begin : g_bad_cfg
    $error("mul_hilo_stage: SETTLE_CYCLES=%0d does not fit CNT_W=%0d", SETTLE_CYCLES, CNT_W);
  end

  mdu_state_t state;
  mdu_state_t state_nxt;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       op_load;
  logic       capture;
  logic       zero_skip;

  mdu_settle_counter #(
    .CNT_W(CNT_W)
  ) u_settle_cnt (
    .clk     (clk),
    .clr     (clr),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(SETTLE_LOAD),
    .cnt_zero(cnt_zero)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start is only looked at in IDLE, so a request during SETTLE is simply dropped.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    op_load   = 1'b0;
    capture   = 1'b0;
    zero_skip = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          op_load = 1'b1;
`ifdef MUL_ZERO_SKIP_EN
          if ((m_in == '0) || (q_in == '0)) begin
            zero_skip = 1'b1;
          end else begin
            cnt_load  = 1'b1;
            state_nxt = SETTLE;
          end
`else
          cnt_load  = 1'b1;
          state_nxt = SETTLE;
`endif
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operands only change on an accepted start so the array input stays quiet otherwise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      m_out <= '0;
      q_out <= '0;
    end else if (op_load) begin
      m_out <= m_in;
      q_out <= q_in;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      done <= 1'b0;
    end else begin
      done <= capture | zero_skip;
    end
  end

  // A multiply result always beats a same-edge bus write to HI/LO.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (capture) begin
      hi_out <= prod_in[63:HI_LSB];
      lo_out <= prod_in[HI_LSB-1:0];
    end else if (zero_skip) begin
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      if (hi_wr) begin
        hi_out <= bus_in;
      end
      if (lo_wr) begin
        lo_out <= bus_in;
      end
    end
  end

  assign busy = (state == SETTLE);

endmodule

// File: tb/tb_mul_hilo_stage.sv
// Self-checking bench for mul_hilo_stage with a behavioural multiplier and reference model.
module tb_mul_hilo_stage;

  localparam int SETTLE = 2;
`ifdef MUL_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] m_in;
  logic [31:0] q_in;
  logic [31:0] m_out;
  logic [31:0] q_out;
  logic [63:0] prod_in;
  logic [31:0] bus_in;
  logic        hi_wr;
  logic        lo_wr;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference state: remaining settle edges, captured product and register images.
  int          mdl_left = 0;
  logic [63:0] mdl_prod = '0;
  logic [31:0] mdl_hi   = '0;
  logic [31:0] mdl_lo   = '0;
  logic [31:0] mdl_m    = '0;
  logic [31:0] mdl_q    = '0;
  logic        mdl_done = 1'b0;

  mul_hilo_stage #(
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (4)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .m_in   (m_in),
    .q_in   (q_in),
    .m_out  (m_out),
    .q_out  (q_out),
    .prod_in(prod_in),
    .bus_in (bus_in),
    .hi_wr  (hi_wr),
    .lo_wr  (lo_wr),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  assign prod_in = longint'($signed(m_out)) * longint'($signed(q_out));

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] m, input logic [31:0] q,
                               input logic hw, input logic lw, input logic [31:0] b);
    @(negedge clk);
    #1;
    start  = s;
    m_in   = m;
    q_in   = q;
    hi_wr  = hw;
    lo_wr  = lw;
    bus_in = b;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Reference model: a multiply takes SETTLE edges after the start edge to land in HI/LO.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mdl_left = 0;
      mdl_prod = '0;
      mdl_hi   = '0;
      mdl_lo   = '0;
      mdl_m    = '0;
      mdl_q    = '0;
      mdl_done = 1'b0;
    end else begin
      mdl_done = 1'b0;
      if (mdl_left > 0) begin
        mdl_left = mdl_left - 1;
        if (mdl_left == 0) begin
          mdl_hi   = mdl_prod[63:32];
          mdl_lo   = mdl_prod[31:0];
          mdl_done = 1'b1;
        end else begin
          if (hi_wr) mdl_hi = bus_in;
          if (lo_wr) mdl_lo = bus_in;
        end
      end else begin
        if (hi_wr) mdl_hi = bus_in;
        if (lo_wr) mdl_lo = bus_in;
        if (start) begin
          mdl_m = m_in;
          mdl_q = q_in;
          if (ZSKIP && ((m_in == 0) || (q_in == 0))) begin
            mdl_hi   = '0;
            mdl_lo   = '0;
            mdl_done = 1'b1;
          end else begin
            mdl_left = SETTLE;
            mdl_prod = longint'($signed(m_in)) * longint'($signed(q_in));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cyc_busy", busy, mdl_left > 0);
      checkOutput("cyc_done", done, mdl_done);
      checkOutput("cyc_hi", hi_out, mdl_hi);
      checkOutput("cyc_lo", lo_out, mdl_lo);
      checkOutput("cyc_m", m_out, mdl_m);
      checkOutput("cyc_q", q_out, mdl_q);
    end
  end

  initial begin
    clr    = 1'b1;
    start  = 1'b0;
    m_in   = '0;
    q_in   = '0;
    hi_wr  = 1'b0;
    lo_wr  = 1'b0;
    bus_in = '0;
    #3;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_hi", hi_out, 0);
    checkOutput("rst_lo", lo_out, 0);
    checkOutput("rst_m", m_out, 0);
    @(negedge clk);
    #2;
    clr = 1'b0;
    chk_en = 1'b1;

    $display("[TB] basic multiply 7 * -3");
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0, 32'd0);
    idle();
    checkOutput("t1_busy1", busy, 1);
    idle();
    checkOutput("t1_busy2", busy, 1);
    checkOutput("t1_nodone", done, 0);
    idle();
    checkOutput("t1_done", done, 1);
    checkOutput("t1_busy_off", busy, 0);
    checkOutput("t1_hi", hi_out, 32'hFFFFFFFF);
    checkOutput("t1_lo", lo_out, 32'hFFFFFFEB);

    $display("[TB] max positive then back-to-back start");
    applyStimulus(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 32'd0);
    idle();
    idle();
    applyStimulus(1'b1, 32'h80000000, 32'd2, 1'b0, 1'b0, 32'd0);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_hi", hi_out, 32'h3FFFFFFF);
    checkOutput("t2_lo", lo_out, 32'h00000001);
    idle();
    checkOutput("t2_b2b_busy", busy, 1);
    idle();
    idle();
    checkOutput("t2_b2b_done", done, 1);
    checkOutput("t2_b2b_hi", hi_out, 32'hFFFFFFFF);
    checkOutput("t2_b2b_lo", lo_out, 32'h00000000);

    $display("[TB] start while busy is ignored");
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0);
    idle();
    idle();
    checkOutput("t3_done", done, 1);
    checkOutput("t3_m", m_out, 32'd7);
    checkOutput("t3_lo", lo_out, 32'hFFFFFFEB);
    idle();
    checkOutput("t3_single_done", done, 0);
    checkOutput("t3_hi_kept", hi_out, 32'hFFFFFFFF);
    checkOutput("t3_lo_kept", lo_out, 32'hFFFFFFEB);

    $display("[TB] bus writes to HI/LO");
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);
    idle();
    checkOutput("t4_hi_wr", hi_out, 32'hDEADBEEF);
    checkOutput("t4_lo_same", lo_out, 32'hFFFFFFEB);
    applyStimulus(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0);
    idle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h12345678);
    idle();
    checkOutput("t4_cap_done", done, 1);
    checkOutput("t4_cap_lo", lo_out, 32'h0000000C);
    checkOutput("t4_cap_hi", hi_out, 32'h00000000);

    $display("[TB] async clear mid-settle");
    applyStimulus(1'b1, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0);
    idle();
    #2;
    clr = 1'b1;
    #1;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_done", done, 0);
    checkOutput("t5_lo", lo_out, 0);
    checkOutput("t5_m", m_out, 0);
    checkOutput("t5_q", q_out, 0);
    #1;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("t5_no_done", done, 0);
      checkOutput("t5_hi_zero", hi_out, 0);
      checkOutput("t5_lo_zero", lo_out, 0);
    end

    $display("[TB] zero operand");
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'hAAAAAAAA);
    applyStimulus(1'b1, 32'd0, 32'd1234, 1'b0, 1'b0, 32'd0);
    checkOutput("t6_hi_pre", hi_out, 32'hAAAAAAAA);
    idle();
`ifdef MUL_ZERO_SKIP_EN
    checkOutput("t6_fast_done", done, 1);
    checkOutput("t6_fast_busy", busy, 0);
    checkOutput("t6_fast_hi", hi_out, 0);
    checkOutput("t6_fast_lo", lo_out, 0);
    checkOutput("t6_fast_q", q_out, 32'd1234);
`else
    checkOutput("t6_slow_busy", busy, 1);
    checkOutput("t6_slow_nodone", done, 0);
    idle();
    idle();
    checkOutput("t6_slow_done", done, 1);
    checkOutput("t6_slow_hi", hi_out, 0);
    checkOutput("t6_slow_lo", lo_out, 0);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic        s;
      logic [31:0] m;
      logic [31:0] q;
      s = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom());
      q = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom());
      applyStimulus(s, m, q, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 32'($urandom()));
    end
    for (int i = 0; i < 4; i++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
